pw_conv_sched: RTL and testbench

// Sequencer for the 1x1 pointwise vector MAC. Walks one layer as oc_grp -> pixel -> ic_grp loops,

---
 rtl/pw_conv_sched.sv | 257 +++++++++++++++++++++++++
 tb/tb_pw_conv_sched.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pw_conv_sched.sv
// -----------------------------------------------------------------------------
// pw_conv_sched
//
// Sequencer for the 1x1 pointwise vector MAC. It walks one layer as nested
// oc_grp -> pixel -> ic_grp loops. It issues sync-read addresses to the
// activation, weight and bias buffers and drives the MAC input handshake with
// aligned first/last input-channel flags. It counts completed MAC outputs and
// pulses done once the whole layer has drained.
//
// Optional feature macro: PW_SCHED_PERF_EN
//   When defined, this adds the perf_stall_cnt and perf_run_cnt outputs.
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   start            begin a layer; cfg_* are sampled on the accepting cycle
//   abort            synchronous abort back to idle; it wins over start/issue
//   cfg_num_ic_grp   IC groups per pixel
//   cfg_num_oc_grp   OC groups per layer
//   cfg_num_pix      pixels per layer
//   busy             high from start accept through the done cycle
//   done             one-cycle pulse at the end of the layer
//   buf_rd_en        read strobe shared by the act/wgt/bias buffers
//   act_addr         pix*num_ic_grp + ic_grp (truncated to ADDR_W)
//   wgt_addr         oc_grp*num_ic_grp + ic_grp (truncated to ADDR_W)
//   bias_addr        oc_grp
//   mac_in_valid     buffer read data valid towards the MAC
//   mac_in_ready     MAC input ready
//   mac_first_in_ch  presented word has ic_grp == 0
//   mac_last_in_ch   presented word has ic_grp == num_ic_grp-1
//   mac_out_fire     MAC output handshake completed
//   perf_stall_cnt   (PW_SCHED_PERF_EN) cycles with mac_in_valid && !mac_in_ready
//   perf_run_cnt     (PW_SCHED_PERF_EN) cycles with busy high
// -----------------------------------------------------------------------------
module pw_conv_sched #(
  parameter int unsigned IC_GRP_W = 8,
  parameter int unsigned OC_GRP_W = 6,
  parameter int unsigned PIX_W    = 12,
  parameter int unsigned ADDR_W   = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [IC_GRP_W-1:0] cfg_num_ic_grp,
  input  logic [OC_GRP_W-1:0] cfg_num_oc_grp,
  input  logic [PIX_W-1:0]    cfg_num_pix,
  output logic                busy,
  output logic                done,
  output logic                buf_rd_en,
  output logic [ADDR_W-1:0]   act_addr,
  output logic [ADDR_W-1:0]   wgt_addr,
  output logic [OC_GRP_W-1:0] bias_addr,
  output logic                mac_in_valid,
  input  logic                mac_in_ready,
  output logic                mac_first_in_ch,
  output logic                mac_last_in_ch,
  input  logic                mac_out_fire
`ifdef PW_SCHED_PERF_EN
  ,
  output logic [31:0]         perf_stall_cnt,
  output logic [31:0]         perf_run_cnt
`endif
);

  localparam int unsigned CNT_W = PIX_W + OC_GRP_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state;

  // Layer configuration latched at start accept
  logic [IC_GRP_W-1:0] nic_q;
  logic [OC_GRP_W-1:0] noc_q;
  logic [PIX_W-1:0]    npix_q;
  logic [CNT_W-1:0]    total_q;

  // Loop counters for the next word to issue
  logic [IC_GRP_W-1:0] ic_cnt;
  logic [PIX_W-1:0]    pix_cnt;
  logic [OC_GRP_W-1:0] oc_cnt;

  // Weight base for the current OC group (oc_grp*num_ic_grp)
  logic [ADDR_W-1:0]   wgt_base;
  logic [CNT_W-1:0]    out_cnt;

  logic                ic_wrap;
  logic                pix_wrap;
  logic                oc_wrap;
  logic                final_issue;
  logic                cfg_zero;
  logic [CNT_W-1:0]    total_in;
  logic [ADDR_W-1:0]   wgt_base_nxt;

  // Issue whenever the output register is empty or being drained this cycle
  assign buf_rd_en = (state == S_RUN) && !abort && (!mac_in_valid || mac_in_ready);

  assign ic_wrap     = (ic_cnt  == (nic_q  - IC_GRP_W'(1)));
  assign pix_wrap    = (pix_cnt == (npix_q - PIX_W'(1)));
  assign oc_wrap     = (oc_cnt  == (noc_q  - OC_GRP_W'(1)));
  assign final_issue = ic_wrap && pix_wrap && oc_wrap;

  assign cfg_zero = (cfg_num_ic_grp == '0) || (cfg_num_oc_grp == '0) || (cfg_num_pix == '0);
  assign total_in = CNT_W'(cfg_num_oc_grp) * CNT_W'(cfg_num_pix);

  assign wgt_base_nxt = wgt_base + ADDR_W'(nic_q);

  // The bias address is the OC-group counter itself, so it is registered.
  assign bias_addr = oc_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      nic_q           <= '0;
      noc_q           <= '0;
      npix_q          <= '0;
      total_q         <= '0;
      ic_cnt          <= '0;
      pix_cnt         <= '0;
      oc_cnt          <= '0;
      act_addr        <= '0;
      wgt_addr        <= '0;
      wgt_base        <= '0;
      out_cnt         <= '0;
      mac_in_valid    <= 1'b0;
      mac_first_in_ch <= 1'b0;
      mac_last_in_ch  <= 1'b0;
    end else if (abort) begin
      state           <= S_IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      ic_cnt          <= '0;
      pix_cnt         <= '0;
      oc_cnt          <= '0;
      act_addr        <= '0;
      wgt_addr        <= '0;
      wgt_base        <= '0;
      out_cnt         <= '0;
      mac_in_valid    <= 1'b0;
      mac_first_in_ch <= 1'b0;
      mac_last_in_ch  <= 1'b0;
    end else begin
      if (mac_out_fire && ((state == S_RUN) || (state == S_DRAIN))) begin
        out_cnt <= out_cnt + CNT_W'(1);
      end

      // The output word register holds until the MAC accepts it.
      if (buf_rd_en) begin
        mac_in_valid    <= 1'b1;
        mac_first_in_ch <= (ic_cnt == '0);
        mac_last_in_ch  <= ic_wrap;
      end else if (mac_in_valid && mac_in_ready) begin
        mac_in_valid <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            nic_q    <= cfg_num_ic_grp;
            noc_q    <= cfg_num_oc_grp;
            npix_q   <= cfg_num_pix;
            total_q  <= total_in;
            ic_cnt   <= '0;
            pix_cnt  <= '0;
            oc_cnt   <= '0;
            act_addr <= '0;
            wgt_addr <= '0;
            wgt_base <= '0;
            out_cnt  <= '0;
            busy     <= 1'b1;
            if (cfg_zero) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_RUN;
            end
          end
        end

        S_RUN: begin
          if (buf_rd_en) begin
            if (final_issue) begin
              state <= S_DRAIN;
            end else if (!ic_wrap) begin
              ic_cnt   <= ic_cnt + IC_GRP_W'(1);
              act_addr <= act_addr + ADDR_W'(1);
              wgt_addr <= wgt_addr + ADDR_W'(1);
            end else if (!pix_wrap) begin
              // Next pixel in the same OC group: weights restart at the group base
              ic_cnt   <= '0;
              pix_cnt  <= pix_cnt + PIX_W'(1);
              act_addr <= act_addr + ADDR_W'(1);
              wgt_addr <= wgt_base;
            end else begin
              // Next OC group: activations restart and the weight base advances
              ic_cnt   <= '0;
              pix_cnt  <= '0;
              oc_cnt   <= oc_cnt + OC_GRP_W'(1);
              act_addr <= '0;
              wgt_base <= wgt_base_nxt;
              wgt_addr <= wgt_base_nxt;
            end
          end
        end

        S_DRAIN: begin
          if (out_cnt == total_q) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PW_SCHED_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_run_cnt   <= '0;
    end else if (abort) begin
      perf_stall_cnt <= '0;
      perf_run_cnt   <= '0;
    end else if ((state == S_IDLE) && start) begin
      perf_stall_cnt <= '0;
      perf_run_cnt   <= '0;
    end else begin
      // Both counters saturate. They hold naturally once idle because busy and valid are low.
      if (busy && (perf_run_cnt != '1)) begin
        perf_run_cnt <= perf_run_cnt + 32'd1;
      end
      if (mac_in_valid && !mac_in_ready && (perf_stall_cnt != '1)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pw_conv_sched.sv
module tb_pw_conv_sched;
  localparam int unsigned IC_GRP_W = 8;
  localparam int unsigned OC_GRP_W = 6;
  localparam int unsigned PIX_W    = 12;
  localparam int unsigned ADDR_W   = 20;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic                abort;
  logic [IC_GRP_W-1:0] cfg_num_ic_grp;
  logic [OC_GRP_W-1:0] cfg_num_oc_grp;
  logic [PIX_W-1:0]    cfg_num_pix;
  logic                busy;
  logic                done;
  logic                buf_rd_en;
  logic [ADDR_W-1:0]   act_addr;
  logic [ADDR_W-1:0]   wgt_addr;
  logic [OC_GRP_W-1:0] bias_addr;
  logic                mac_in_valid;
  logic                mac_in_ready;
  logic                mac_first_in_ch;
  logic                mac_last_in_ch;
  logic                mac_out_fire;
`ifdef PW_SCHED_PERF_EN
  logic [31:0]         perf_stall_cnt;
  logic [31:0]         perf_run_cnt;
`endif

  always #5 clk = ~clk;

  pw_conv_sched #(
    .IC_GRP_W(IC_GRP_W),
    .OC_GRP_W(OC_GRP_W),
    .PIX_W   (PIX_W),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .abort          (abort),
    .cfg_num_ic_grp (cfg_num_ic_grp),
    .cfg_num_oc_grp (cfg_num_oc_grp),
    .cfg_num_pix    (cfg_num_pix),
    .busy           (busy),
    .done           (done),
    .buf_rd_en      (buf_rd_en),
    .act_addr       (act_addr),
    .wgt_addr       (wgt_addr),
    .bias_addr      (bias_addr),
    .mac_in_valid   (mac_in_valid),
    .mac_in_ready   (mac_in_ready),
    .mac_first_in_ch(mac_first_in_ch),
    .mac_last_in_ch (mac_last_in_ch),
    .mac_out_fire   (mac_out_fire)
`ifdef PW_SCHED_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_run_cnt   (perf_run_cnt)
`endif
  );

  typedef struct {
    logic [ADDR_W-1:0]   act;
    logic [ADDR_W-1:0]   wgt;
    logic [OC_GRP_W-1:0] bias;
    logic                first;
    logic                last;
  } word_t;

  word_t             exp_q[$];
  logic [ADDR_W-1:0] cap_act[$];
  logic [ADDR_W-1:0] cap_wgt[$];
  logic [OC_GRP_W-1:0] cap_bias[$];

  int checks = 0;
  int errors = 0;
  int issue_idx, cons_idx, fired_cnt, pend_out, done_cnt, rd_en_cnt;
  int busy_cyc, stall_cyc, exp_outs, man_req;
  bit auto_fire;
  bit prev_stall;
  logic [ADDR_W-1:0] prev_act, prev_wgt;
  logic prev_first, prev_last;

  int t1_act[6]  = '{0, 1, 2, 3, 4, 5};
  int t1_wgt[6]  = '{0, 1, 0, 1, 0, 1};
  int t3_act[4]  = '{0, 1, 0, 1};
  int t3_wgt[4]  = '{0, 0, 1, 1};
  int t3_bias[4] = '{0, 0, 1, 1};

  task automatic chk(input string name, input logic [63:0] actual, input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  // Reference word sequence straight from the loop nest definition
  task automatic build_model(input int nic, input int noc, input int npix);
    exp_q.delete();
    cap_act.delete();
    cap_wgt.delete();
    cap_bias.delete();
    for (int oc = 0; oc < noc; oc++) begin
      for (int p = 0; p < npix; p++) begin
        for (int ic = 0; ic < nic; ic++) begin
          word_t w;
          w.act   = ADDR_W'(p * nic + ic);
          w.wgt   = ADDR_W'(oc * nic + ic);
          w.bias  = OC_GRP_W'(oc);
          w.first = (ic == 0);
          w.last  = (ic == nic - 1);
          exp_q.push_back(w);
        end
      end
    end
    exp_outs  = (nic == 0) ? 0 : noc * npix;
    issue_idx = 0;
    cons_idx  = 0;
    fired_cnt = 0;
    pend_out  = 0;
    rd_en_cnt = 0;
    busy_cyc  = 0;
    stall_cyc = 0;
  endtask

  task automatic do_start(input int nic, input int noc, input int npix);
    @(posedge clk); #1;
    cfg_num_ic_grp = IC_GRP_W'(nic);
    cfg_num_oc_grp = OC_GRP_W'(noc);
    cfg_num_pix    = PIX_W'(npix);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, done, 1);
  endtask

  // Compare process: scoreboard of issued and consumed words on every cycle
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      chk("done_words", cons_idx, exp_q.size());
      chk("done_issues", issue_idx, exp_q.size());
      chk("done_outs", fired_cnt, exp_outs);
    end
    if (busy === 1'b1) busy_cyc++;
    if (mac_in_valid && !mac_in_ready) begin
      stall_cyc++;
      chk("stall_rd_en", buf_rd_en, 0);
    end
    if (prev_stall) begin
      chk("stall_valid", mac_in_valid, 1);
      chk("stall_act", act_addr, prev_act);
      chk("stall_wgt", wgt_addr, prev_wgt);
      chk("stall_first", mac_first_in_ch, prev_first);
      chk("stall_last", mac_last_in_ch, prev_last);
    end
    if (buf_rd_en === 1'b1) begin
      rd_en_cnt++;
      cap_act.push_back(act_addr);
      cap_wgt.push_back(wgt_addr);
      cap_bias.push_back(bias_addr);
      if (issue_idx < exp_q.size()) begin
        chk("issue_act", act_addr, exp_q[issue_idx].act);
        chk("issue_wgt", wgt_addr, exp_q[issue_idx].wgt);
        chk("issue_bias", bias_addr, exp_q[issue_idx].bias);
      end else begin
        chk("issue_count", issue_idx + 1, exp_q.size());
      end
      issue_idx++;
    end
    if (mac_in_valid === 1'b1 && mac_in_ready === 1'b1) begin
      if (cons_idx < exp_q.size()) begin
        chk("word_first", mac_first_in_ch, exp_q[cons_idx].first);
        chk("word_last", mac_last_in_ch, exp_q[cons_idx].last);
        if (exp_q[cons_idx].last) pend_out++;
      end else begin
        chk("word_count", cons_idx + 1, exp_q.size());
      end
      cons_idx++;
    end
    prev_stall = (mac_in_valid === 1'b1) && (mac_in_ready === 1'b0);
    prev_act   = act_addr;
    prev_wgt   = wgt_addr;
    prev_first = mac_first_in_ch;
    prev_last  = mac_last_in_ch;
  end

  // MAC output side: one completed output per consumed last_in_ch word
  initial begin
    mac_out_fire = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (auto_fire && pend_out > 0) begin
        mac_out_fire = 1'b1;
        pend_out--;
        fired_cnt++;
      end else if (!auto_fire && man_req > 0) begin
        mac_out_fire = 1'b1;
        man_req--;
        fired_cnt++;
      end else begin
        mac_out_fire = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n;
    int d0;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_num_ic_grp = '0; cfg_num_oc_grp = '0; cfg_num_pix = '0;
    mac_in_ready = 1'b1; auto_fire = 1'b1; man_req = 0;
    done_cnt = 0; prev_stall = 1'b0;
    build_model(0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", buf_rd_en, 0);
    chk("rst_valid", mac_in_valid, 0);
    chk("rst_act", act_addr, 0);
    chk("rst_wgt", wgt_addr, 0);
    chk("rst_bias", bias_addr, 0);
    chk("rst_first", mac_first_in_ch, 0);
    chk("rst_last", mac_last_in_ch, 0);

    // ic=2 oc=1 pix=3, ready always high
    build_model(2, 1, 3);
    do_start(2, 1, 3);
    @(negedge clk);
    chk("t1_busy", busy, 1);
    chk("t1_rd_en_c1", buf_rd_en, 1);
    chk("t1_valid_c1", mac_in_valid, 0);
    @(negedge clk);
    chk("t1_valid_c2", mac_in_valid, 1);
    chk("t1_first_c2", mac_first_in_ch, 1);
    wait_done(50, "t1_done");
    @(negedge clk);
    chk("t1_idle_busy", busy, 0);
    chk("t1_n_issues", cap_act.size(), 6);
    for (int i = 0; i < 6 && i < cap_act.size(); i++) begin
      chk("t1_act_lit", cap_act[i], t1_act[i]);
      chk("t1_wgt_lit", cap_wgt[i], t1_wgt[i]);
    end

    // Same layer with a 3-cycle MAC stall mid-run
    build_model(2, 1, 3);
    do_start(2, 1, 3);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 mac_in_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 mac_in_ready = 1'b1;
    wait_done(50, "t2_done");
    @(negedge clk);
    chk("t2_stall_cycles", stall_cyc, 3);
    chk("t2_n_issues", cap_act.size(), 6);
    for (int i = 0; i < 6 && i < cap_act.size(); i++) begin
      chk("t2_act_lit", cap_act[i], t1_act[i]);
      chk("t2_wgt_lit", cap_wgt[i], t1_wgt[i]);
    end
`ifdef PW_SCHED_PERF_EN
    chk("t2_perf_stall", perf_stall_cnt, 3);
    chk("t2_perf_run", perf_run_cnt, busy_cyc);
    n = busy_cyc;
    repeat (3) @(negedge clk);
    chk("t2_perf_stall_hold", perf_stall_cnt, 3);
    chk("t2_perf_run_hold", perf_run_cnt, n);
`endif

    // ic=1 oc=2 pix=2, MAC outputs released by hand
    build_model(1, 2, 2);
    auto_fire = 1'b0;
    d0 = done_cnt;
    do_start(1, 2, 2);
    n = 0;
    while (cons_idx < 4 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("t3_words", cons_idx, 4);
    repeat (5) @(negedge clk);
    chk("t3_no_done_0", done_cnt, d0);
    for (int k = 0; k < 3; k++) begin
      man_req = 1;
      repeat (3) @(negedge clk);
    end
    chk("t3_no_done_3", done_cnt, d0);
    chk("t3_busy_3", busy, 1);
    man_req = 1;
    wait_done(20, "t3_done");
    @(negedge clk);
    chk("t3_done_once", done_cnt, d0 + 1);
    for (int i = 0; i < 4 && i < cap_act.size(); i++) begin
      chk("t3_act_lit", cap_act[i], t3_act[i]);
      chk("t3_wgt_lit", cap_wgt[i], t3_wgt[i]);
      chk("t3_bias_lit", cap_bias[i], t3_bias[i]);
    end
    pend_out = 0;
    auto_fire = 1'b1;

    // Zero pixels: straight to done, no buffer reads
    build_model(2, 1, 0);
    do_start(2, 1, 0);
    @(negedge clk);
    chk("t4_busy", busy, 1);
    chk("t4_done", done, 1);
    @(negedge clk);
    chk("t4_busy_off", busy, 0);
    chk("t4_done_off", done, 0);
    chk("t4_rd_en_cnt", rd_en_cnt, 0);

    // start while busy is ignored
    build_model(2, 1, 3);
    d0 = done_cnt;
    do_start(2, 1, 3);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    cfg_num_ic_grp = 1; cfg_num_oc_grp = 2; cfg_num_pix = 2;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(50, "t5_done");
    repeat (10) @(negedge clk);
    chk("t5_done_once", done_cnt, d0 + 1);

    // abort mid-run
    build_model(2, 1, 3);
    d0 = done_cnt;
    do_start(2, 1, 3);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_valid", mac_in_valid, 0);
    chk("abort_rd_en", buf_rd_en, 0);
    chk("abort_act", act_addr, 0);
    repeat (6) @(negedge clk);
    chk("abort_no_done", done_cnt, d0);
    pend_out = 0;

    // asynchronous reset mid-run, away from the clock edge
    build_model(2, 1, 3);
    do_start(2, 1, 3);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", mac_in_valid, 0);
    chk("arst_rd_en", buf_rd_en, 0);
    @(posedge clk); #1 rst = 1'b0;
    pend_out = 0;

    // recovery run after reset
    build_model(2, 1, 3);
    do_start(2, 1, 3);
    wait_done(50, "rec_done");
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
